// File: rtl/seven_seg_counter_mux_if.sv
// Control, count and display signals of the seven-segment counter.
// The controller drives master; the counter implements slave.
interface seven_seg_counter_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      en;
    logic                      clr;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   load_val;
    logic                      load_dir;
    logic [4*NUM_DIGITS-1:0]   value;
    logic                      dir;
    logic                      tick;
    logic [NUM_DIGITS-1:0]     digit_sel;
    logic [6:0]                seg;
    logic                      dp;

    modport master (
        output en, clr, load, load_val, load_dir,
        input  value, dir, tick, digit_sel, seg, dp
    );

    modport slave (
        input  en, clr, load, load_val, load_dir,
        output value, dir, tick, digit_sel, seg, dp
    );
endinterface

// File: rtl/seven_seg_counter_mux.sv
// N-digit hex/BCD up/down counter with bounce or wrap at the limits,
// driving a multiplexed seven-segment bank with optional zero blanking.
module seven_seg_counter_mux #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TICK_HZ    = 1,
    parameter int SCAN_HZ    = 1000,
    parameter int NUM_DIGITS = 4,
    parameter int BCD        = 0,
    parameter int BOUNCE     = 1,
    parameter int BLANK_LZ   = 0
) (
    input logic clk,
    input logic rst_n,
    seven_seg_counter_mux_if.slave bus
);
    localparam int W        = 4 * NUM_DIGITS;
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int SCAN_DIV = CLK_HZ / (SCAN_HZ * NUM_DIGITS);
    localparam int TW       = $clog2(TICK_DIV);
    localparam int SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [3:0] DMAX = (BCD != 0) ? 4'd9 : 4'hF;

    logic [TW-1:0]         pre_q;
    logic [W-1:0]          val_q, val_d, val_inc, val_dec, val_ld;
    logic                  dir_q, dir_d;
    logic                  step;
    logic                  is_max, is_zero;
    logic                  cin, bin;
    logic [3:0]            nib;
    logic [SW-1:0]         scnt_q;
    logic [IW-1:0]         idx_q;
    logic [3:0]            cur_nib;
    logic                  zrun, blank;
    logic [NUM_DIGITS-1:0] hz, sel_d;
    logic [6:0]            seg_d;
    logic [NUM_DIGITS-1:0] sel_q;
    logic [6:0]            seg_q;
    logic                  dp_q;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        s = 7'h00;
        case (d)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h73;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

    // Step strobe: prescaler at terminal count, not overridden by clr/load
    always_comb begin
        step = bus.en & ~bus.clr & ~bus.load
             & (pre_q == TW'(TICK_DIV - 1));
        is_max  = (val_q == {NUM_DIGITS{DMAX}});
        is_zero = (val_q == '0);
    end

    // Per-nibble increment/decrement and BCD clamp of the load value
    always_comb begin
        val_inc = val_q;
        val_dec = val_q;
        val_ld  = bus.load_val;
        cin     = 1'b1;
        bin     = 1'b1;
        nib     = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib = val_q[i*4 +: 4];
            if (cin) begin
                if (nib == DMAX) begin
                    val_inc[i*4 +: 4] = 4'd0;
                end else begin
                    val_inc[i*4 +: 4] = nib + 4'd1;
                    cin = 1'b0;
                end
            end
            if (bin) begin
                if (nib == 4'd0) begin
                    val_dec[i*4 +: 4] = DMAX;
                end else begin
                    val_dec[i*4 +: 4] = nib - 4'd1;
                    bin = 1'b0;
                end
            end
            if (BCD != 0 && val_ld[i*4 +: 4] > 4'd9) begin
                val_ld[i*4 +: 4] = 4'd9;
            end
        end
    end

    // Next value/direction on a step, bouncing or wrapping at the limits
    always_comb begin
        val_d = val_q;
        dir_d = dir_q;
        if (step) begin
            if (!dir_q) begin
                if (BOUNCE != 0 && is_max) begin
                    val_d = val_dec;
                    dir_d = 1'b1;
                end else begin
                    val_d = val_inc;
                end
            end else begin
                if (BOUNCE != 0 && is_zero) begin
                    val_d = val_inc;
                    dir_d = 1'b0;
                end else begin
                    val_d = val_dec;
                end
            end
        end
    end

    // Count state: clr beats load beats the enabled prescaler/step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            val_q <= '0;
            dir_q <= 1'b0;
        end else if (bus.clr) begin
            pre_q <= '0;
            val_q <= '0;
            dir_q <= 1'b0;
        end else if (bus.load) begin
            pre_q <= '0;
            val_q <= val_ld;
            dir_q <= bus.load_dir;
        end else if (bus.en) begin
            pre_q <= step ? '0 : pre_q + 1'b1;
            val_q <= val_d;
            dir_q <= dir_d;
        end
    end

    // Free-running scan divider and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt_q <= '0;
            idx_q  <= '0;
        end else if (scnt_q == SW'(SCAN_DIV - 1)) begin
            scnt_q <= '0;
            idx_q  <= (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            scnt_q <= scnt_q + 1'b1;
        end
    end

    // Select the scanned nibble and decide leading-zero blanking
    always_comb begin
        cur_nib = 4'd0;
        sel_d   = '0;
        hz      = '0;
        zrun    = 1'b1;
        blank   = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zrun  = zrun & (val_q[i*4 +: 4] == 4'd0);
            hz[i] = zrun;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib  = val_q[i*4 +: 4];
                sel_d[i] = 1'b1;
                blank    = (BLANK_LZ != 0) && (i != 0) && hz[i];
            end
        end
        seg_d = blank ? 7'h00 : seg_of(cur_nib);
    end

    // Registered display outputs, one cycle behind idx/value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= '0;
            seg_q <= '0;
            dp_q  <= 1'b0;
        end else begin
            sel_q <= sel_d;
            seg_q <= seg_d;
            dp_q  <= (idx_q == '0) && dir_q;
        end
    end

    assign bus.value     = val_q;
    assign bus.dir       = dir_q;
    assign bus.tick      = step;
    assign bus.digit_sel = sel_q;
    assign bus.seg       = seg_q;
    assign bus.dp        = dp_q;
endmodule

// File: tb/tb_seven_seg_counter_mux.sv
// Directed bench: four counter variants (hex/BCD x bounce/wrap)
// driven from one stimulus set and checked against hand values.
module tb_seven_seg_counter_mux;
    logic       clk;
    logic       rst_n;
    logic       en, clr, load, load_dir;
    logic [7:0] load_val;
    int         n_chk;
    int         n_fail;

    seven_seg_counter_mux_if #(.NUM_DIGITS(2)) ifa ();
    seven_seg_counter_mux_if #(.NUM_DIGITS(2)) ifb ();
    seven_seg_counter_mux_if #(.NUM_DIGITS(2)) ifc ();
    seven_seg_counter_mux_if #(.NUM_DIGITS(2)) ifd ();

    assign {ifa.en, ifa.clr, ifa.load, ifa.load_dir, ifa.load_val} =
           {en, clr, load, load_dir, load_val};
    assign {ifb.en, ifb.clr, ifb.load, ifb.load_dir, ifb.load_val} =
           {en, clr, load, load_dir, load_val};
    assign {ifc.en, ifc.clr, ifc.load, ifc.load_dir, ifc.load_val} =
           {en, clr, load, load_dir, load_val};
    assign {ifd.en, ifd.clr, ifd.load, ifd.load_dir, ifd.load_val} =
           {en, clr, load, load_dir, load_val};

    // hex, bounce
    seven_seg_counter_mux #(
        .CLK_HZ(100), .TICK_HZ(10), .SCAN_HZ(10), .NUM_DIGITS(2),
        .BCD(0), .BOUNCE(1), .BLANK_LZ(0)
    ) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));

    // BCD, bounce, blanking
    seven_seg_counter_mux #(
        .CLK_HZ(100), .TICK_HZ(10), .SCAN_HZ(10), .NUM_DIGITS(2),
        .BCD(1), .BOUNCE(1), .BLANK_LZ(1)
    ) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    // hex, wrap
    seven_seg_counter_mux #(
        .CLK_HZ(100), .TICK_HZ(10), .SCAN_HZ(10), .NUM_DIGITS(2),
        .BCD(0), .BOUNCE(0), .BLANK_LZ(0)
    ) u_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    // BCD, wrap
    seven_seg_counter_mux #(
        .CLK_HZ(100), .TICK_HZ(10), .SCAN_HZ(10), .NUM_DIGITS(2),
        .BCD(1), .BOUNCE(0), .BLANK_LZ(0)
    ) u_d (.clk(clk), .rst_n(rst_n), .bus(ifd));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!ifa.tick && n < 40);
        if (!ifa.tick) check("tick_timeout", 32'(n), 32'd0);
    endtask

    task automatic do_load(input logic [7:0] v, input logic d);
        load     = 1'b1;
        load_val = v;
        load_dir = d;
        step_edge();
        load = 1'b0;
    endtask

    int n;
    int seen0, seen1;
    logic [1:0] s0, prev, exp_sel;

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        en = 1'b0;
        clr = 1'b0;
        load = 1'b0;
        load_dir = 1'b0;
        load_val = 8'h00;

        // reset state, held across a clock edge
        @(negedge clk);
        step_edge();
        check("rst_value", 32'(ifa.value), 32'h0);
        check("rst_dir", 32'(ifa.dir), 32'h0);
        check("rst_tick", 32'(ifa.tick), 32'h0);
        check("rst_sel", 32'(ifa.digit_sel), 32'h0);
        check("rst_seg", 32'(ifa.seg), 32'h0);
        check("rst_dp", 32'(ifa.dp), 32'h0);

        // 1: count, tick period, enable hold
        rst_n = 1'b1;
        en = 1'b1;
        step_edge();
        check("first_sel", 32'(ifa.digit_sel), 32'h1);
        check("first_seg", 32'(ifa.seg), 32'h7E);
        wait_tick(n);
        check("first_tick", 32'(n), 32'd8);
        step_edge();
        check("cnt_01", 32'(ifa.value), 32'h01);
        wait_tick(n);
        check("tick_period", 32'(n), 32'd9);
        step_edge();
        check("cnt_02", 32'(ifa.value), 32'h02);
        en = 1'b0;
        repeat (7) step_edge();
        check("hold_val", 32'(ifa.value), 32'h02);
        check("hold_tick", 32'(ifa.tick), 32'h0);
        en = 1'b1;
        wait_tick(n);
        check("hold_delay", 32'(1 + 7 + n), 32'd17);
        step_edge();
        check("cnt_03", 32'(ifd.value), 32'h03);

        // 2: hex carry, BCD clamp, bounce at max, wrap at max
        do_load(8'h0F, 1'b0);
        check("ld_0F_hex", 32'(ifa.value), 32'h0F);
        check("ld_0F_bcd", 32'(ifb.value), 32'h09);
        wait_tick(n);
        check("ld_restart", 32'(n), 32'd9);
        step_edge();
        check("hex_carry", 32'(ifa.value), 32'h10);
        check("bcd_carry", 32'(ifb.value), 32'h10);
        do_load(8'hFF, 1'b0);
        wait_tick(n);
        step_edge();
        check("bnc_max_hex", 32'({ifa.dir, ifa.value}), 32'h1FE);
        check("bnc_max_bcd", 32'({ifb.dir, ifb.value}), 32'h198);
        check("wrap_max_hex", 32'({ifc.dir, ifc.value}), 32'h000);
        check("wrap_max_bcd", 32'({ifd.dir, ifd.value}), 32'h000);
        wait_tick(n);
        step_edge();
        check("bnc_down", 32'(ifa.value), 32'hFD);

        // 3: BCD digit carry and clamp on load
        do_load(8'h09, 1'b0);
        wait_tick(n);
        step_edge();
        check("bcd_09_up", 32'(ifb.value), 32'h10);
        do_load(8'hAB, 1'b0);
        check("ld_AB_bcd", 32'(ifb.value), 32'h99);
        check("ld_AB_hex", 32'(ifa.value), 32'hAB);

        // 4: down at zero
        do_load(8'h00, 1'b1);
        wait_tick(n);
        step_edge();
        check("bnc_zero_hex", 32'({ifa.dir, ifa.value}), 32'h001);
        check("bnc_zero_bcd", 32'({ifb.dir, ifb.value}), 32'h001);
        check("wrap_zero_hex", 32'({ifc.dir, ifc.value}), 32'h1FF);
        check("wrap_zero_bcd", 32'({ifd.dir, ifd.value}), 32'h199);

        // 5: scan of 0x3A, no blanking, dir up
        en = 1'b0;
        do_load(8'h3A, 1'b0);
        step_edge();
        prev = ifa.digit_sel;
        n = 0;
        do begin
            step_edge();
            n++;
        end while (ifa.digit_sel == prev && n < 12);
        check("scan_move", 32'(ifa.digit_sel != prev), 32'h1);
        s0 = ifa.digit_sel;
        for (int k = 0; k < 10; k++) begin
            exp_sel = (k < 5) ? s0 : (s0 ^ 2'b11);
            check("scan_sel", 32'(ifa.digit_sel), 32'(exp_sel));
            check("scan_seg", 32'(ifa.seg),
                  (exp_sel == 2'b01) ? 32'h77 : 32'h79);
            check("scan_dp", 32'(ifa.dp), 32'h0);
            step_edge();
        end

        // 5b: blanking of 0x05 on B, shown zero on A, dp with dir down
        do_load(8'h05, 1'b1);
        step_edge();
        seen0 = 0;
        seen1 = 0;
        for (int k = 0; k < 10; k++) begin
            if (ifb.digit_sel == 2'b01) begin
                seen0++;
                check("blk_d0_seg", 32'(ifb.seg), 32'h5B);
                check("blk_d0_dp", 32'(ifb.dp), 32'h1);
            end else begin
                seen1++;
                check("blk_d1_sel", 32'(ifb.digit_sel), 32'h2);
                check("blk_d1_seg", 32'(ifb.seg), 32'h00);
                check("blk_d1_dp", 32'(ifb.dp), 32'h0);
            end
            if (ifa.digit_sel == 2'b10) begin
                check("noblk_d1_seg", 32'(ifa.seg), 32'h7E);
            end
            step_edge();
        end
        check("blk_seen_d0", 32'(seen0 > 0), 32'h1);
        check("blk_seen_d1", 32'(seen1 > 0), 32'h1);

        // 6: clr over load, async reset mid-count, resume
        en = 1'b1;
        clr = 1'b1;
        load = 1'b1;
        load_val = 8'h55;
        load_dir = 1'b1;
        step_edge();
        clr = 1'b0;
        load = 1'b0;
        check("clr_load", 32'({ifa.dir, ifa.value}), 32'h000);
        do_load(8'h42, 1'b0);
        repeat (3) step_edge();
        #2 rst_n = 1'b0;
        #1;
        check("arst_value", 32'(ifa.value), 32'h0);
        check("arst_seg", 32'(ifa.seg), 32'h0);
        check("arst_sel", 32'(ifa.digit_sel), 32'h0);
        check("arst_tick", 32'(ifa.tick), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step_edge();
        wait_tick(n);
        check("resume_tick", 32'(n), 32'd8);
        step_edge();
        check("resume_val", 32'(ifa.value), 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
